// File: rtl/radix4_multiplier.sv
// radix4_multiplier
//
// Sequential unsigned 64x64 -> 128-bit multiplier. Two multiplier bits are
// retired per clock (radix-4), so every operation takes exactly 32 EXEC
// cycles regardless of operand values.
//
// Ports:
//   clk          rising-edge system clock
//   reset_n      asynchronous reset, ACTIVE HIGH despite the suffix
//   multiplier   operand A, sampled only on the start edge
//   multiplicand operand B, sampled only on the start edge
//   op_start     level; starts an operation when sampled high in IDLE
//   op_clear     level; synchronous return to IDLE, beats any other action
//   op_done      high while the result is valid (state DONE)
//   result       A*B while op_done=1, otherwise zero
//
// Handshake: op_start acts as a request that is accepted only on an edge
// where the block is in IDLE and op_clear is low; op_done then stays high
// with result valid until the requester pulses op_clear. There is no
// backpressure: a request outside IDLE is simply ignored.

module radix4_multiplier (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [63:0]  multiplier,
    input  logic [63:0]  multiplicand,
    input  logic         op_start,
    input  logic         op_clear,
    output logic         op_done,
    output logic [127:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [4:0]    cnt;
    logic [63:0]   mr;
    logic [65:0]   m1;
    logic [65:0]   m3;
    logic [127:0]  acc;

    logic [65:0]   pp;
    logic [127:0]  pp_shifted;
    logic [65:0]   m3_init;

    // 3*B is precomputed at start so each step is a pure select + add.
    assign m3_init = {2'b00, multiplicand} + {1'b0, multiplicand, 1'b0};

    // Radix-4 digit select: 0, B, 2B or 3B.
    always_comb begin
        pp = '0;
        case (mr[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = m1;
            2'd2:    pp = {m1[64:0], 1'b0};
            default: pp = m3;
        endcase
    end

    // Partial product aligned to the digit position 2*cnt.
    assign pp_shifted = {62'd0, pp} << {cnt, 1'b0};

    // Next-state logic; op_clear overrides every state.
    always_comb begin
        state_next = state;
        if (op_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (op_start) state_next = EXEC;
                EXEC:    if (cnt == 5'd31) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt <= '0;
            acc <= '0;
            mr  <= '0;
            m1  <= '0;
            m3  <= '0;
        end else if (op_clear) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        mr  <= multiplier;
                        m1  <= {2'b00, multiplicand};
                        m3  <= m3_init;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                EXEC: begin
                    acc <= acc + pp_shifted;
                    mr  <= mr >> 2;
                    cnt <= cnt + 5'd1;  // wraps to 0 as the block enters DONE
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode the state register only; partial sums never leak out.
    assign op_done = (state == DONE);
    assign result  = (state == DONE) ? acc : '0;

endmodule

// File: doc/radix4_multiplier.md
# radix4_multiplier

Sequential unsigned 64×64 → 128-bit multiplier that retires two multiplier bits per clock (radix-4, 32 iterations). It sits directly under the factorial controller. That controller loads the running product and the current operand, pulses start, waits for done, then clears the multiplier before the next step. Timing is fixed and operand-independent, so the controller's WAIT state and the bench can count cycles exactly.

## Interface
Parameters:
- none (widths fixed: 64-bit operands, 128-bit result, 32 iterations)

Ports:
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous, active-high reset (high = reset, despite the suffix)
- multiplier  in  64  operand A, unsigned; sampled only on the start edge
- multiplicand  in  64  operand B, unsigned; sampled only on the start edge
- op_start  in  1  level; begins an operation when sampled high in IDLE
- op_clear  in  1  level; synchronous clear, highest priority after reset
- op_done  out  1  high while the result is valid (state DONE)
- result  out  128  A×B when op_done=1, otherwise 128'h0

## Operation
- States: IDLE, EXEC, DONE.
  - Encoding is free.
  - The registered state, 5-bit iteration count `cnt`, 64-bit shift register `mr`, 66-bit `m1`/`m3`, and 128-bit accumulator `acc` are the only storage.
- Reset (async, reset_n=1) puts the block in this state:
  - state=IDLE, cnt=0, acc=0, mr=0, m1=0, m3=0
  - op_done=0, result=0
- Priority at each edge: op_clear > state-specific action.
  - op_clear=1 in any state → IDLE, acc=0, cnt=0, op_done=0.
- IDLE:
  - op_start=1 and op_clear=0 → latch mr=multiplier, m1=multiplicand, m3=3×multiplicand (66-bit), acc=0, cnt=0.
  - Then go to EXEC.
- EXEC, one step per edge:
  - d = mr[1:0].
  - acc += (d==0 ? 0 : d==1 ? m1 : d==2 ? m1<<1 : m3) << (2×cnt).
  - mr >>= 2, cnt += 1.
  - When cnt==31 on this edge, go to DONE.
- DONE:
  - Hold acc; op_done=1.
  - op_start is ignored; leave only via op_clear or reset.
- Inputs ignored outside the IDLE start edge:
  - op_start in EXEC is ignored.
  - Operand changes in EXEC or DONE have no effect.
- Arithmetic:
  - All math is unsigned modulo 2^128.
  - The product of two 64-bit values never overflows 128 bits, so result is exact.
- Output: result = (state==DONE) ? acc : 0, so partial sums are never visible.
- op_done is a registered state decode; it is glitch-free.

## Timing
- Edge S samples op_start=1 in IDLE.
  - EXEC runs on edges S+1 through S+32.
  - op_done and result become valid after edge S+32 (32-cycle latency from the start edge) and stay valid until clear or reset.
- The latency is independent of operand values; there is no early termination.
- op_clear and op_start high on the same edge in IDLE → stay in IDLE; no start.
- op_clear asserted mid-EXEC → IDLE on that edge, and the partial acc is discarded.
  - A new start is accepted on the next edge if op_start=1 and op_clear=0.
- op_clear held high → stays in IDLE, with result=0 and op_done=0.
- reset_n asserted mid-operation → immediate async return to the reset state.
  - The first edge after deassertion behaves as IDLE.
- Back-to-back use (the controller pattern) is start → done → clear → start.
  - Minimum cycle from one start edge to the next is 34 edges: 32 EXEC, 1 clear, 1 start.

## Test plan
- Reset then start with A=3, B=5 → op_done rises exactly 32 cycles after the start edge, result=128'h0F. Before that, result=0 and op_done=0.
- A=B=64'hFFFF_FFFF_FFFF_FFFF → result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Also A=0, B=any → result=0 with the same 32-cycle latency.
- Start A=20, B=6; change the operands and toggle op_start during EXEC → result=120 at S+32, unaffected. Holding op_start in DONE does not restart.
- Start, then assert op_clear at S+10 → IDLE and op_done never rises. Restart with A=7, B=9 → 63 at 32 cycles after the new start. Simultaneous op_start+op_clear in IDLE → no start.
- Assert reset_n at S+15, release and restart A=12, B=11 → result=132. Reset values are checked immediately on assertion, without waiting for a clock.
- Controller-style chain computing 20! (start/done/clear per step, multiplicand = previous result[63:0]) → final result=128'h21C3_677C_82B4_0000. Each step's latency is checked at exactly 32 cycles.
